// File: rtl/sound_pkg.sv
// Shared definitions for the buzzer sequencer: event codes, FSM states,
// note half-periods at 50 MHz, sequence lengths and request-set helpers.
package sound_pkg;

    localparam logic [1:0] SOUND_NONE       = 2'b00;
    localparam logic [1:0] SOUND_EAT_FOOD   = 2'b01;
    localparam logic [1:0] SOUND_GAME_OVER  = 2'b10;
    localparam logic [1:0] SOUND_GAME_START = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NOTE = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [15:0] HP_C5 = 16'd47801;
    localparam logic [15:0] HP_E5 = 16'd37936;
    localparam logic [15:0] HP_G5 = 16'd31888;
    localparam logic [15:0] HP_C6 = 16'd23889;

    localparam logic [1:0] LEN_EAT_FOOD   = 2'd1;
    localparam logic [1:0] LEN_GAME_START = 2'd3;
    localparam logic [1:0] LEN_GAME_OVER  = 2'd3;

    // Pending/request bits are indexed by event code; code 00 maps to nothing.
    function automatic logic [3:1] code_bit(input logic [1:0] code);
        code_bit = '0;
        case (code)
            SOUND_EAT_FOOD:   code_bit[1] = 1'b1;
            SOUND_GAME_OVER:  code_bit[2] = 1'b1;
            SOUND_GAME_START: code_bit[3] = 1'b1;
            default:          code_bit    = '0;
        endcase
    endfunction

    function automatic logic [1:0] pick_code(input logic [3:1] req);
        if (req[2])      pick_code = SOUND_GAME_OVER;
        else if (req[3]) pick_code = SOUND_GAME_START;
        else if (req[1]) pick_code = SOUND_EAT_FOOD;
        else             pick_code = SOUND_NONE;
    endfunction

endpackage

// File: rtl/sound_note_rom.sv
// Combinational note table: (event code, note index) -> tone half-period
// in 50 MHz clocks and a flag marking the final note of the sequence.
module sound_note_rom
    import sound_pkg::*;
(
    input  logic [1:0]  code,
    input  logic [1:0]  index,
    output logic [15:0] half_period,
    output logic        last_note
);

    always_comb begin
        half_period = '0;
        last_note   = 1'b1;
        case (code)
            SOUND_EAT_FOOD: begin
                half_period = HP_C6;
                last_note   = (index == LEN_EAT_FOOD - 2'd1);
            end
            SOUND_GAME_START: begin
                case (index)
                    2'd0:    half_period = HP_C5;
                    2'd1:    half_period = HP_E5;
                    default: half_period = HP_G5;
                endcase
                last_note = (index == LEN_GAME_START - 2'd1);
            end
            SOUND_GAME_OVER: begin
                case (index)
                    2'd0:    half_period = HP_G5;
                    2'd1:    half_period = HP_E5;
                    default: half_period = HP_C5;
                endcase
                last_note = (index == LEN_GAME_OVER - 2'd1);
            end
            default: begin
                half_period = '0;
                last_note   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/sound_event_scheduler.sv
// Buzzer sequencer: queues sound requests and plays their note sequences in
// priority order. Define SOUND_PREEMPT_EN to let GAME_OVER abort other sequences.
//
// state | meaning
// IDLE  | silent, waiting for a request
// NOTE  | tone playing for NOTE_TICKS cycles
// GAP   | silent spacer of GAP_TICKS cycles after every note
module sound_event_scheduler
    import sound_pkg::*;
#(
    parameter int          M          = 2,
    parameter logic [25:0] NOTE_TICKS = 26'd5_000_000,
    parameter logic [25:0] GAP_TICKS  = 26'd500_000,
    parameter int          HP_SHIFT   = 0
) (
    input  logic         clk,
    input  logic         reset_global,
    input  logic [M-1:0] sound_event_code_in,
    input  logic         sound_trigger_in,
    output logic         buzzer_out,
    output logic         busy_out,
    output logic [M-1:0] playing_code_out,
    output logic [1:0]   note_index_out
);

    state_t      state, state_nxt;
    logic [1:0]  code_r, code_nxt;
    logic [1:0]  idx_r, idx_nxt;
    logic [25:0] tick_cnt, tick_nxt;
    logic [15:0] tone_cnt, tone_nxt;
    logic        buzzer, buzzer_nxt;
    logic [3:1]  pending, pending_nxt;

    logic [3:1]  trig_bits;
    logic [3:1]  req_set;
    logic [1:0]  sel_code;
    logic [15:0] rom_hp;
    logic [15:0] hp_shifted;
    logic [15:0] hp;
    logic        last_note;

    sound_note_rom u_rom (
        .code        (code_r),
        .index       (idx_r),
        .half_period (rom_hp),
        .last_note   (last_note)
    );

    assign hp_shifted = rom_hp >> HP_SHIFT;
    assign hp         = (hp_shifted == 16'd0) ? 16'd1 : hp_shifted;

    assign trig_bits = sound_trigger_in ? code_bit(sound_event_code_in) : '0;
    assign req_set   = pending | trig_bits;
    assign sel_code  = pick_code(req_set);

    always_comb begin
        state_nxt   = state;
        code_nxt    = code_r;
        idx_nxt     = idx_r;
        tick_nxt    = tick_cnt;
        tone_nxt    = tone_cnt;
        buzzer_nxt  = buzzer;
        pending_nxt = req_set;

        case (state)
            IDLE: begin
                buzzer_nxt = 1'b0;
                tick_nxt   = '0;
                tone_nxt   = '0;
                if (req_set != '0) begin
                    state_nxt   = NOTE;
                    code_nxt    = sel_code;
                    idx_nxt     = 2'd0;
                    pending_nxt = req_set & ~code_bit(sel_code);
                end
            end
            NOTE: begin
                if (tick_cnt == NOTE_TICKS - 26'd1) begin
                    state_nxt  = GAP;
                    tick_nxt   = '0;
                    tone_nxt   = '0;
                    buzzer_nxt = 1'b0;
                end else begin
                    tick_nxt = tick_cnt + 26'd1;
                    if (tone_cnt == hp - 16'd1) begin
                        tone_nxt   = '0;
                        buzzer_nxt = ~buzzer;
                    end else begin
                        tone_nxt = tone_cnt + 16'd1;
                    end
                end
            end
            GAP: begin
                buzzer_nxt = 1'b0;
                tone_nxt   = '0;
                if (tick_cnt == GAP_TICKS - 26'd1) begin
                    tick_nxt = '0;
                    if (!last_note) begin
                        state_nxt = NOTE;
                        idx_nxt   = idx_r + 2'd1;
                    end else if (req_set != '0) begin
                        // Chain straight into the next queued sequence, no IDLE cycle.
                        state_nxt   = NOTE;
                        code_nxt    = sel_code;
                        idx_nxt     = 2'd0;
                        pending_nxt = req_set & ~code_bit(sel_code);
                    end else begin
                        state_nxt = IDLE;
                        code_nxt  = SOUND_NONE;
                        idx_nxt   = 2'd0;
                    end
                end else begin
                    tick_nxt = tick_cnt + 26'd1;
                end
            end
            default: begin
                state_nxt  = IDLE;
                code_nxt   = SOUND_NONE;
                idx_nxt    = 2'd0;
                tick_nxt   = '0;
                tone_nxt   = '0;
                buzzer_nxt = 1'b0;
            end
        endcase

`ifdef SOUND_PREEMPT_EN
        // The aborted sequence is simply dropped; the triggering request is consumed.
        if (state != IDLE && trig_bits[2] && code_r != SOUND_GAME_OVER) begin
            state_nxt   = NOTE;
            code_nxt    = SOUND_GAME_OVER;
            idx_nxt     = 2'd0;
            tick_nxt    = '0;
            tone_nxt    = '0;
            buzzer_nxt  = 1'b0;
            pending_nxt = pending & ~code_bit(SOUND_GAME_OVER);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset_global) begin
            state    <= IDLE;
            code_r   <= SOUND_NONE;
            idx_r    <= 2'd0;
            tick_cnt <= '0;
            tone_cnt <= '0;
            buzzer   <= 1'b0;
            pending  <= '0;
        end else begin
            state    <= state_nxt;
            code_r   <= code_nxt;
            idx_r    <= idx_nxt;
            tick_cnt <= tick_nxt;
            tone_cnt <= tone_nxt;
            buzzer   <= buzzer_nxt;
            pending  <= pending_nxt;
        end
    end

    assign buzzer_out       = buzzer;
    assign busy_out         = (state != IDLE);
    assign playing_code_out = code_r;
    assign note_index_out   = idx_r;

endmodule

// File: tb/tb_sound_event_scheduler.sv
// Directed bench for sound_event_scheduler with short note/gap timing;
// the preemption scenario follows SOUND_PREEMPT_EN when it is defined.
module tb_sound_event_scheduler;

    logic       clk = 1'b0;
    logic       reset_global;
    logic [1:0] code_in;
    logic       trig;
    logic       buzzer;
    logic       busy;
    logic [1:0] play_code;
    logic [1:0] note_idx;

    int checks = 0;
    int errors = 0;

    sound_event_scheduler #(
        .M          (2),
        .NOTE_TICKS (26'd40),
        .GAP_TICKS  (26'd4),
        .HP_SHIFT   (12)
    ) dut (
        .clk                 (clk),
        .reset_global        (reset_global),
        .sound_event_code_in (code_in),
        .sound_trigger_in    (trig),
        .buzzer_out          (buzzer),
        .busy_out            (busy),
        .playing_code_out    (play_code),
        .note_index_out      (note_idx)
    );

    always #5 clk = ~clk;

    // Observation point sits 1 time unit after the rising edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic [1:0] c);
        code_in = c;
        trig    = 1'b1;
        step(1);
        trig    = 1'b0;
        code_in = 2'b00;
    endtask

    function automatic logic tone(input int k, input int hp);
        return ((((k - 1) / hp) % 2) == 1);
    endfunction

    task automatic test_reset;
        reset_global = 1'b1;
        step(3);
        reset_global = 1'b0;
        step(1);
        checks++;
        if ({busy, play_code, note_idx, buzzer} !== 6'b0) begin
            errors++;
            $display("FAIL reset_state got %b expected %b", {busy, play_code, note_idx, buzzer}, 6'b0);
        end
    endtask

    task automatic test_eat;
        logic [5:0] exp;
        int toggles = 0;
        logic prev;
        pulse(2'b01);
        prev = 1'b0;
        for (int k = 1; k <= 44; k++) begin
            exp = {1'b1, 2'b01, 2'b00, (k <= 40) ? tone(k, 5) : 1'b0};
            checks++;
            if ({busy, play_code, note_idx, buzzer} !== exp) begin
                errors++;
                $display("FAIL eat_cycle%0d got %b expected %b", k, {busy, play_code, note_idx, buzzer}, exp);
            end
            if (buzzer !== prev) toggles++;
            prev = buzzer;
            step(1);
        end
        checks++;
        if (toggles != 8) begin
            errors++;
            $display("FAIL eat_toggles got %0d expected 8", toggles);
        end
        checks++;
        if ({busy, play_code} !== 3'b000) begin
            errors++;
            $display("FAIL eat_idle got %b expected 000", {busy, play_code});
        end
    endtask

    task automatic test_start;
        int hps[3] = '{11, 9, 7};
        logic [5:0] exp;
        int bad = 0;
        pulse(2'b11);
        for (int n = 0; n < 3; n++) begin
            for (int k = 1; k <= 44; k++) begin
                exp = {1'b1, 2'b11, 2'(n), (k <= 40) ? tone(k, hps[n]) : 1'b0};
                if ({busy, play_code, note_idx, buzzer} !== exp) begin
                    bad++;
                    if (bad < 4)
                        $display("FAIL start_note%0d_cycle%0d got %b expected %b", n, k,
                                 {busy, play_code, note_idx, buzzer}, exp);
                end
                step(1);
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL start_sequence got %0d bad cycles expected 0", bad);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_busy_133 got %b expected 0", busy);
        end
    endtask

    task automatic test_back_to_back;
        int low = 0;
        pulse(2'b11);
        step(19);
        pulse(2'b01);
        for (int c = 21; c < 132; c++) begin
            if (busy !== 1'b1) low++;
            step(1);
        end
        checks++;
        if (low != 0) begin
            errors++;
            $display("FAIL queue_busy_gap got %0d low cycles expected 0", low);
        end
        checks++;
        if ({busy, play_code, note_idx, buzzer} !== 6'b1_11_10_0) begin
            errors++;
            $display("FAIL queue_last_gap got %b expected 111100", {busy, play_code, note_idx, buzzer});
        end
        step(1);
        checks++;
        if ({busy, play_code, note_idx, buzzer} !== 6'b1_01_00_0) begin
            errors++;
            $display("FAIL queue_eat_start got %b expected 101000", {busy, play_code, note_idx, buzzer});
        end
        step(44);
        checks++;
        if ({busy, play_code} !== 3'b000) begin
            errors++;
            $display("FAIL queue_idle got %b expected 000", {busy, play_code});
        end
    endtask

    task automatic test_collapse;
        pulse(2'b10);
        step(4);
        pulse(2'b01);
        step(44);
        pulse(2'b01);
        step(49);
        pulse(2'b01);
        step(31);
        checks++;
        if ({busy, play_code, note_idx, buzzer} !== 6'b1_10_10_0) begin
            errors++;
            $display("FAIL collapse_go_end got %b expected 110100", {busy, play_code, note_idx, buzzer});
        end
        step(1);
        checks++;
        if ({busy, play_code, note_idx, buzzer} !== 6'b1_01_00_0) begin
            errors++;
            $display("FAIL collapse_eat got %b expected 101000", {busy, play_code, note_idx, buzzer});
        end
        step(44);
        checks++;
        if ({busy, play_code} !== 3'b000) begin
            errors++;
            $display("FAIL collapse_idle got %b expected 000", {busy, play_code});
        end
        step(10);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL collapse_single got busy %b expected 0", busy);
        end
    endtask

    task automatic test_preempt;
        pulse(2'b01);
        step(9);
        pulse(2'b10);
`ifdef SOUND_PREEMPT_EN
        checks++;
        if ({busy, play_code, note_idx, buzzer} !== 6'b1_10_00_0) begin
            errors++;
            $display("FAIL preempt_switch got %b expected 110000", {busy, play_code, note_idx, buzzer});
        end
        step(131);
        checks++;
        if ({busy, play_code, note_idx, buzzer} !== 6'b1_10_10_0) begin
            errors++;
            $display("FAIL preempt_go_end got %b expected 110100", {busy, play_code, note_idx, buzzer});
        end
        step(1);
        checks++;
        if ({busy, play_code} !== 3'b000) begin
            errors++;
            $display("FAIL preempt_idle got %b expected 000", {busy, play_code});
        end
        step(5);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL preempt_no_resume got busy %b expected 0", busy);
        end
`else
        checks++;
        if ({busy, play_code, note_idx, buzzer} !== 6'b1_01_00_0) begin
            errors++;
            $display("FAIL queued_go_eat_cont got %b expected 101000", {busy, play_code, note_idx, buzzer});
        end
        step(33);
        checks++;
        if ({busy, play_code, note_idx, buzzer} !== 6'b1_01_00_0) begin
            errors++;
            $display("FAIL queued_go_eat_gap got %b expected 101000", {busy, play_code, note_idx, buzzer});
        end
        step(1);
        checks++;
        if ({busy, play_code, note_idx, buzzer} !== 6'b1_10_00_0) begin
            errors++;
            $display("FAIL queued_go_start got %b expected 110000", {busy, play_code, note_idx, buzzer});
        end
        step(132);
        checks++;
        if ({busy, play_code} !== 3'b000) begin
            errors++;
            $display("FAIL queued_go_idle got %b expected 000", {busy, play_code});
        end
`endif
        step(5);
    endtask

    task automatic test_mid_reset;
        pulse(2'b11);
        step(3);
        pulse(2'b01);
        step(10);
        checks++;
        if (buzzer !== 1'b1) begin
            errors++;
            $display("FAIL midreset_tone got %b expected 1", buzzer);
        end
        reset_global = 1'b1;
        step(1);
        reset_global = 1'b0;
        checks++;
        if ({busy, play_code, note_idx, buzzer} !== 6'b0) begin
            errors++;
            $display("FAIL midreset_state got %b expected 000000", {busy, play_code, note_idx, buzzer});
        end
        step(5);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_pending got busy %b expected 0", busy);
        end
        pulse(2'b00);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL code00_ignored got busy %b expected 0", busy);
        end
        step(3);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL code00_stays_idle got busy %b expected 0", busy);
        end
    endtask

    initial begin
        reset_global = 1'b1;
        code_in      = 2'b00;
        trig         = 1'b0;
        #1;
        test_reset;
        test_eat;
        step(3);
        test_start;
        step(3);
        test_back_to_back;
        step(3);
        test_collapse;
        step(3);
        test_preempt;
        test_mid_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
